// File: rtl/write_back_multi_if.sv
// MEM-to-write-back and ecall-unit handshakes. master = environment (MEM stage
// plus ecall unit), slave = the write-back stage.
interface write_back_multi_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic            in_we;
  logic            in_is_ecall;
  logic [XLEN-1:0] in_data;
  logic [63:0]     in_pc;
  logic            ecall_req;
  logic [63:0]     ecall_pc;
  logic            ecall_ack;
  logic [XLEN-1:0] ecall_result;

  modport master (
    output in_valid, in_rd, in_we, in_is_ecall, in_data, in_pc, ecall_ack, ecall_result,
    input  in_ready, ecall_req, ecall_pc
  );

  modport slave (
    input  in_valid, in_rd, in_we, in_is_ecall, in_data, in_pc, ecall_ack, ecall_result,
    output in_ready, ecall_req, ecall_pc
  );
endinterface

// File: rtl/write_back_multi.sv
// Multi-lane write-back: in-order retire queue feeding RETIRE_W register-file
// write lanes, with ECALLs serialised through a req/ack handshake.
module write_back_multi #(
  parameter int XLEN     = 64,
  parameter int DEPTH    = 4,
  parameter int RETIRE_W = 2,
  parameter int CNT_W    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  write_back_multi_if.slave        bus,
  input  logic                     flush,
  output logic [RETIRE_W-1:0]      rf_we,
  output logic [5*RETIRE_W-1:0]    rf_addr,
  output logic [XLEN*RETIRE_W-1:0] rf_data,
  output logic [RETIRE_W-1:0]      clr_valid,
  output logic [5*RETIRE_W-1:0]    clr_addr,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         retired_total
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int KW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] we_q;
  logic [DEPTH-1:0] ecall_q;
  logic [4:0]       rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [63:0]      pc_q   [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [OW-1:0]    count_q;
  logic [CNT_W-1:0] retired_q;
  state_e           state_q;
  state_e           phase_s;
  logic [63:0]      ecall_pc_q;

  logic [PW-1:0]       lane_idx_s [RETIRE_W];
  logic [RETIRE_W-1:0] retire_s;
  logic [KW-1:0]       k_s;
  logic                chain_s;
  logic                hit_s;
  logic                enq_s;
  logic                ack_fire_s;
  logic                head_ecall_s;

  assign bus.in_ready  = (count_q < OW'(DEPTH));
  assign bus.ecall_req = (state_q == ST_REQ);
  assign bus.ecall_pc  = ecall_pc_q;
  assign occupancy     = count_q;
  assign retired_total = retired_q;

  assign enq_s        = bus.in_valid && bus.in_ready && !flush;
  assign ack_fire_s   = (phase_s == ST_ACK);
  assign head_ecall_s = (count_q != '0) && valid_q[head_q] && ecall_q[head_q];

  // Lane i looks at the i-th oldest queued entry.
  always_comb begin
    for (int i = 0; i < RETIRE_W; i++) begin
      lane_idx_s[i] = head_q + PW'(i);
    end
  end

  // ACK is the Mealy view of REQ in the cycle the ecall unit answers.
  always_comb begin
    if ((state_q == ST_REQ) && bus.ecall_ack) begin
      phase_s = ST_ACK;
    end else begin
      phase_s = state_q;
    end
  end

  // Retire group: consecutive lanes, stopped by an empty slot, an unacked ECALL or a same-cycle WAW.
  always_comb begin
    rf_we     = '0;
    rf_addr   = '0;
    rf_data   = '0;
    clr_valid = '0;
    clr_addr  = '0;
    retire_s  = '0;
    k_s       = '0;
    chain_s   = 1'b1;
    hit_s     = 1'b0;
    for (int i = 0; i < RETIRE_W; i++) begin
      hit_s = 1'b0;
      for (int j = 0; j < i; j++) begin
        hit_s = hit_s | (rf_we[j] && (rf_addr[5*j +: 5] == rd_q[lane_idx_s[i]]));
      end
      chain_s = chain_s && (i < DEPTH) && valid_q[lane_idx_s[i]] && !hit_s &&
                (!ecall_q[lane_idx_s[i]] || ((i == 0) && ack_fire_s));
      if (chain_s) begin
        retire_s[i]              = 1'b1;
        rf_we[i]                 = (rd_q[lane_idx_s[i]] != 5'd0) &&
                                   (ecall_q[lane_idx_s[i]] || we_q[lane_idx_s[i]]);
        rf_addr[5*i +: 5]        = rd_q[lane_idx_s[i]];
        rf_data[XLEN*i +: XLEN]  = ecall_q[lane_idx_s[i]] ? bus.ecall_result : data_q[lane_idx_s[i]];
        clr_valid[i]             = (rd_q[lane_idx_s[i]] != 5'd0);
        clr_addr[5*i +: 5]       = rd_q[lane_idx_s[i]];
        k_s                      = k_s + KW'(1);
      end else begin
        retire_s[i] = 1'b0;
      end
    end
  end

  // Next valid map: drop retired slots, claim the tail slot on enqueue.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < RETIRE_W; i++) begin
      valid_d[lane_idx_s[i]] = valid_d[lane_idx_s[i]] & ~retire_s[i];
    end
    valid_d[tail_q] = valid_d[tail_q] | enq_s;
  end

  // Queue pointers, occupancy and retired counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      retired_q <= '0;
      valid_q   <= '0;
    end else begin
      retired_q <= retired_q + CNT_W'(k_s);
      if (flush) begin
        valid_q <= '0;
        head_q  <= tail_q;
        count_q <= '0;
      end else begin
        valid_q <= valid_d;
        head_q  <= head_q + PW'(k_s);
        tail_q  <= tail_q + PW'(enq_s);
        count_q <= count_q + OW'(enq_s) - OW'(k_s);
      end
    end
  end

  // Entry payload; only the valid map needs reset.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      rd_q[tail_q]    <= bus.in_rd;
      we_q[tail_q]    <= bus.in_we;
      ecall_q[tail_q] <= bus.in_is_ecall;
      data_q[tail_q]  <= bus.in_data;
      pc_q[tail_q]    <= bus.in_pc;
    end
  end

  // ECALL handshake FSM; ecall_pc is latched on entry to REQ so it holds until ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ecall_pc_q <= '0;
    end else if (flush) begin
      state_q    <= ST_IDLE;
      ecall_pc_q <= '0;
    end else begin
      case (phase_s)
        ST_IDLE: begin
          if (head_ecall_s) begin
            state_q    <= ST_REQ;
            ecall_pc_q <= pc_q[head_q];
          end else begin
            state_q    <= ST_IDLE;
            ecall_pc_q <= '0;
          end
        end
        ST_REQ: begin
          state_q    <= ST_REQ;
          ecall_pc_q <= ecall_pc_q;
        end
        ST_ACK: begin
          state_q    <= ST_IDLE;
          ecall_pc_q <= '0;
        end
        default: begin
          state_q    <= ST_IDLE;
          ecall_pc_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_write_back_multi.sv
// Bench for write_back_multi: hand-computed vector table, directed flush/reset
// sequences, and randomised traffic against a queue-based reference model.
module tb_write_back_multi;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int RW    = 2;
  localparam int CNT_W = 64;

  logic               clk   = 1'b0;
  logic               reset = 1'b0;
  logic               flush = 1'b0;
  logic [RW-1:0]      rf_we;
  logic [RW-1:0]      clr_valid;
  logic [5*RW-1:0]    rf_addr;
  logic [5*RW-1:0]    clr_addr;
  logic [XLEN*RW-1:0] rf_data;
  logic [2:0]         occupancy;
  logic [CNT_W-1:0]   retired_total;
  int                 total = 0;
  int                 bad   = 0;

  write_back_multi_if #(.XLEN(XLEN)) bus ();

  write_back_multi #(.XLEN(XLEN), .DEPTH(DEPTH), .RETIRE_W(RW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .flush(flush),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .clr_valid(clr_valid), .clr_addr(clr_addr),
    .occupancy(occupancy), .retired_total(retired_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] rd; logic we; logic ec; logic [63:0] d; logic [63:0] pc;
    logic ack; logic [63:0] res;
    logic [1:0] ewe; logic [9:0] eaddr; logic [127:0] edata; logic [1:0] eclr;
    logic [2:0] occ; logic [63:0] tot; logic req; logic rdy;
  } vec_t;

  typedef struct {
    logic [4:0] rd; logic we; logic ec; logic [63:0] d; logic [63:0] pc;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];
  logic m_req;
  logic [63:0] m_tot;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [4:0] rd, input logic we, input logic ec,
                     input logic [63:0] d, input logic [63:0] pc, input logic ack, input logic [63:0] res,
                     input logic [1:0] ewe, input logic [9:0] eaddr, input logic [127:0] edata,
                     input logic [1:0] eclr, input logic [2:0] occ, input logic [63:0] tot,
                     input logic req, input logic rdy);
    vec_t t;
    t.v = v; t.rd = rd; t.we = we; t.ec = ec; t.d = d; t.pc = pc; t.ack = ack; t.res = res;
    t.ewe = ewe; t.eaddr = eaddr; t.edata = edata; t.eclr = eclr;
    t.occ = occ; t.tot = tot; t.req = req; t.rdy = rdy;
    vecs.push_back(t);
  endtask

  // Drive one cycle's inputs just after the falling edge and let them settle.
  task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic ec,
                       input logic [63:0] d, input logic [63:0] pc, input logic ack,
                       input logic [63:0] res, input logic fl);
    @(negedge clk);
    bus.in_valid     = v;
    bus.in_rd        = rd;
    bus.in_we        = we;
    bus.in_is_ecall  = ec;
    bus.in_data      = d;
    bus.in_pc        = pc;
    bus.ecall_ack    = ack;
    bus.ecall_result = res;
    flush            = fl;
    #1;
  endtask

  task automatic run_random(input int cycles);
    logic v, we, ec, ack, fl, rdy, nreq;
    logic [4:0] rd;
    logic [63:0] d, pc, res;
    logic [1:0] ewe, eclr;
    logic [9:0] eaddr;
    logic [127:0] edata;
    logic [31:0] wmask;
    logic w;
    int k;
    ent_t e;
    for (int c = 0; c < cycles; c++) begin
      v   = ($urandom_range(0, 9) < 7);
      rd  = 5'($urandom_range(0, 7));
      we  = ($urandom_range(0, 4) != 0);
      ec  = ($urandom_range(0, 9) == 0);
      d   = {$urandom, $urandom};
      pc  = {$urandom, $urandom};
      ack = ($urandom_range(0, 2) == 0);
      res = {$urandom, $urandom};
      fl  = ($urandom_range(0, 49) == 0);
      drive(v, rd, we, ec, d, pc, ack, res, fl);

      rdy = (mq.size() < DEPTH);
      ewe = '0; eclr = '0; eaddr = '0; edata = '0; wmask = '0; k = 0;
      for (int i = 0; i < RW; i++) begin
        if (i >= mq.size()) break;
        e = mq[i];
        if (e.ec && !(i == 0 && m_req && ack)) break;
        if (wmask[e.rd]) break;
        w = (e.rd != 5'd0) && (e.ec || e.we);
        if (w) wmask[e.rd] = 1'b1;
        ewe[i]            = w;
        eclr[i]           = (e.rd != 5'd0);
        eaddr[5*i +: 5]   = e.rd;
        edata[64*i +: 64] = e.ec ? res : e.d;
        k++;
      end

      chk($sformatf("rnd%0d.in_ready", c), bus.in_ready, rdy);
      chk($sformatf("rnd%0d.ecall_req", c), bus.ecall_req, m_req);
      chk($sformatf("rnd%0d.occupancy", c), occupancy, mq.size());
      chk($sformatf("rnd%0d.retired_total", c), retired_total, m_tot);
      chk($sformatf("rnd%0d.rf_we", c), rf_we, ewe);
      chk($sformatf("rnd%0d.rf_addr", c), rf_addr, eaddr);
      chk($sformatf("rnd%0d.rf_data", c), rf_data, edata);
      chk($sformatf("rnd%0d.clr_valid", c), clr_valid, eclr);
      chk($sformatf("rnd%0d.clr_addr", c), clr_addr, eaddr);
      if (m_req) chk($sformatf("rnd%0d.ecall_pc", c), bus.ecall_pc, mq[0].pc);

      nreq = m_req ? !ack : ((mq.size() > 0) && mq[0].ec);
      for (int i = 0; i < k; i++) void'(mq.pop_front());
      m_tot = m_tot + 64'(k);
      if (fl) begin
        mq.delete();
        m_req = 1'b0;
      end else begin
        m_req = nreq;
        if (v && rdy) begin
          e.rd = rd; e.we = we; e.ec = ec; e.d = d; e.pc = pc;
          mq.push_back(e);
        end
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_we = 1'b0; bus.in_is_ecall = 1'b0;
    bus.in_data = '0; bus.in_pc = '0; bus.ecall_ack = 1'b0; bus.ecall_result = '0;

    // Columns: v rd we ec data pc ack result | rf_we rf_addr rf_data clr_valid occ total req ready
    add(1, 5,  1, 0, 64'hA,    64'h0,   0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd0, 64'd0,  0, 1);
    add(1, 6,  1, 0, 64'hB,    64'h0,   0, 64'h0,  2'b01, {5'd0, 5'd5},   {64'h0, 64'hA},          2'b01, 3'd1, 64'd0,  0, 1);
    add(0, 0,  0, 0, 64'h0,    64'h0,   0, 64'h0,  2'b01, {5'd0, 5'd6},   {64'h0, 64'hB},          2'b01, 3'd1, 64'd1,  0, 1);
    add(0, 0,  0, 0, 64'h0,    64'h0,   0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd0, 64'd2,  0, 1);
    add(1, 10, 1, 1, 64'h0,    64'h100, 0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd0, 64'd2,  0, 1);
    add(1, 11, 1, 0, 64'h11,   64'h0,   0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd1, 64'd2,  0, 1);
    add(1, 12, 1, 0, 64'h12,   64'h0,   0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd2, 64'd2,  1, 1);
    add(0, 0,  0, 0, 64'h0,    64'h0,   0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd3, 64'd2,  1, 1);
    add(0, 0,  0, 0, 64'h0,    64'h0,   1, 64'd24, 2'b11, {5'd11, 5'd10}, {64'h11, 64'd24},        2'b11, 3'd3, 64'd2,  1, 1);
    add(0, 0,  0, 0, 64'h0,    64'h0,   0, 64'h0,  2'b01, {5'd0, 5'd12},  {64'h0, 64'h12},         2'b01, 3'd1, 64'd4,  0, 1);
    add(0, 0,  0, 0, 64'h0,    64'h0,   0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd0, 64'd5,  0, 1);
    add(1, 0,  1, 1, 64'h0,    64'h200, 0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd0, 64'd5,  0, 1);
    add(1, 0,  0, 0, 64'h55,   64'h0,   0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd1, 64'd5,  0, 1);
    add(1, 7,  1, 0, 64'h1,    64'h0,   0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd2, 64'd5,  1, 1);
    add(1, 7,  1, 0, 64'h2,    64'h0,   0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd3, 64'd5,  1, 1);
    add(0, 0,  0, 0, 64'h0,    64'h0,   0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd4, 64'd5,  1, 0);
    add(0, 0,  0, 0, 64'h0,    64'h0,   1, 64'h99, 2'b00, 10'd0,          {64'h55, 64'h99},        2'b00, 3'd4, 64'd5,  1, 0);
    add(0, 0,  0, 0, 64'h0,    64'h0,   0, 64'h0,  2'b01, {5'd0, 5'd7},   {64'h0, 64'h1},          2'b01, 3'd2, 64'd7,  0, 1);
    add(0, 0,  0, 0, 64'h0,    64'h0,   0, 64'h0,  2'b01, {5'd0, 5'd7},   {64'h0, 64'h2},          2'b01, 3'd1, 64'd8,  0, 1);
    add(1, 0,  1, 0, 64'h77,   64'h0,   0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd0, 64'd9,  0, 1);
    add(0, 0,  0, 0, 64'h0,    64'h0,   0, 64'h0,  2'b00, 10'd0,          {64'h0, 64'h77},         2'b00, 3'd1, 64'd9,  0, 1);
    add(0, 0,  0, 0, 64'h0,    64'h0,   0, 64'h0,  2'b00, 10'd0,          128'h0,                  2'b00, 3'd0, 64'd10, 0, 1);

    // Reset state
    #2;
    chk("rst.rf_we", rf_we, 2'b00);
    chk("rst.clr_valid", clr_valid, 2'b00);
    chk("rst.occupancy", occupancy, 3'd0);
    chk("rst.retired_total", retired_total, 64'd0);
    chk("rst.ecall_req", bus.ecall_req, 1'b0);
    chk("rst.in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[n]) begin
      drive(vecs[n].v, vecs[n].rd, vecs[n].we, vecs[n].ec, vecs[n].d, vecs[n].pc,
            vecs[n].ack, vecs[n].res, 1'b0);
      chk($sformatf("tab%0d.rf_we", n), rf_we, vecs[n].ewe);
      chk($sformatf("tab%0d.rf_addr", n), rf_addr, vecs[n].eaddr);
      chk($sformatf("tab%0d.rf_data", n), rf_data, vecs[n].edata);
      chk($sformatf("tab%0d.clr_valid", n), clr_valid, vecs[n].eclr);
      chk($sformatf("tab%0d.clr_addr", n), clr_addr, vecs[n].eaddr);
      chk($sformatf("tab%0d.occupancy", n), occupancy, vecs[n].occ);
      chk($sformatf("tab%0d.retired_total", n), retired_total, vecs[n].tot);
      chk($sformatf("tab%0d.ecall_req", n), bus.ecall_req, vecs[n].req);
      chk($sformatf("tab%0d.in_ready", n), bus.in_ready, vecs[n].rdy);
    end

    // Flush with three queued entries (ECALL stalled in REQ) and a concurrent enqueue
    drive(1, 5'd3, 1, 1, 64'h0, 64'h300, 0, 64'h0, 0);
    drive(1, 5'd4, 1, 0, 64'h4, 64'h0,   0, 64'h0, 0);
    drive(1, 5'd5, 1, 0, 64'h5, 64'h0,   0, 64'h0, 0);
    drive(1, 5'd9, 1, 0, 64'h9, 64'h0,   0, 64'h0, 1);
    chk("flush.occ_before", occupancy, 3'd3);
    chk("flush.req_before", bus.ecall_req, 1'b1);
    chk("flush.pc_before", bus.ecall_pc, 64'h300);
    drive(0, 5'd0, 0, 0, 64'h0, 64'h0, 0, 64'h0, 0);
    chk("flush.occ_after", occupancy, 3'd0);
    chk("flush.req_after", bus.ecall_req, 1'b0);
    chk("flush.rf_we_after", rf_we, 2'b00);
    chk("flush.total_after", retired_total, 64'd10);
    drive(0, 5'd0, 0, 0, 64'h0, 64'h0, 0, 64'h0, 0);
    chk("flush.enq_dropped", occupancy, 3'd0);
    chk("flush.total_stable", retired_total, 64'd10);

    // Asynchronous reset while an ECALL is waiting in REQ
    drive(1, 5'd1, 1, 1, 64'h0, 64'h400, 0, 64'h0, 0);
    drive(0, 5'd0, 0, 0, 64'h0, 64'h0,   0, 64'h0, 0);
    drive(0, 5'd0, 0, 0, 64'h0, 64'h0,   0, 64'h0, 0);
    chk("areset.req_before", bus.ecall_req, 1'b1);
    chk("areset.pc_before", bus.ecall_pc, 64'h400);
    reset = 1'b0;
    #1;
    chk("areset.req_dropped", bus.ecall_req, 1'b0);
    chk("areset.occupancy", occupancy, 3'd0);
    chk("areset.retired_total", retired_total, 64'd0);
    chk("areset.in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;

    mq.delete();
    m_req = 1'b0;
    m_tot = 64'd0;
    run_random(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
